pc_sequencer: RTL

//   Owns the program counter and sequences the branch-target adder of the datapath.

---
 rtl/pc_seq_pkg.sv | 17 +
 rtl/pc_target_adder.sv | 13 +
 rtl/pc_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state encoding,
// datapath width and default reset vector / sequential step.
package pc_seq_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] DEFAULT_RESET_VECTOR = 32'h0000_3000;
    localparam logic [PC_W-1:0] DEFAULT_PC_STEP      = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/pc_target_adder.sv
// Branch-target adder: sequential PC plus the pre-shifted, sign-extended offset.
// Plain modulo-2^32 add, no carry out.
module pc_target_adder
    import pc_seq_pkg::*;
(
    input  logic [PC_W-1:0] base,
    input  logic [PC_W-1:0] offset,
    output logic [PC_W-1:0] target
);

    assign target = base + offset;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: fetches over req/ack, holds on stall, selects PC+4 / branch / jump.
// Optional macro BRANCH_DELAY_SLOT_EN defers taken redirects by one slot instruction.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] PC_STEP      = DEFAULT_PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_take,
    input  logic [31:0] branch_off,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        pc_misalign,
    output logic [1:0]  fsm_state
);

    // Handshake: imem_req rises on entry to S_FETCH and stays high with a stable
    // imem_addr until a cycle in which imem_ack is sampled high at posedge clk.

    state_t      state;
    logic [31:0] pc;
    logic [31:0] branch_target;
    logic [31:0] redirect_pc;
    logic [31:0] next_pc;
    logic        redirect;

`ifdef BRANCH_DELAY_SLOT_EN
    logic        pend_valid;
    logic [31:0] pend_target;
`endif

    assign pc_out    = pc;
    assign imem_addr = pc;
    assign pc_plus4  = pc + PC_STEP;
    assign fsm_state = state;

    pc_target_adder u_target_adder (
        .base   (pc_plus4),
        .offset (branch_off),
        .target (branch_target)
    );

    always_comb begin
        redirect    = jump_en | branch_take;
        redirect_pc = jump_en ? jump_target : branch_target;
`ifdef BRANCH_DELAY_SLOT_EN
        // The slot instruction always falls through to the stored target.
        next_pc     = pend_valid ? pend_target : pc_plus4;
`else
        next_pc     = redirect ? redirect_pc : pc_plus4;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= RESET_VECTOR;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            pc_misalign <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
            pend_valid  <= 1'b0;
            pend_target <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        state       <= S_EXEC;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
                        if (pend_valid) begin
                            pend_valid <= 1'b0;
                        end else if (redirect) begin
                            pend_valid  <= 1'b1;
                            pend_target <= redirect_pc;
                        end
`endif
                        // A misaligned PC is still committed so it can be inspected.
                        if (next_pc[1:0] != 2'b00) begin
                            pc_misalign <= 1'b1;
                            state       <= S_HALT;
                        end else begin
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end
                default: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
